// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester/transmitter bundle for the UART tx arbiter
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   ack;
    logic [7:0]           tx_data;
    logic                 tx_transmit;
    logic                 busy;
    logic [IDW-1:0]       grant_id;

    modport master (
        output req, req_data,
        input  ack, tx_data, tx_transmit, busy, grant_id
    );

    modport slave (
        input  req, req_data,
        output ack, tx_data, tx_transmit, busy, grant_id
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 10417,
    parameter int FRAME_BITS   = 10,
    parameter int HOLD_CYCLES  = 2
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int FRAME_CYCLES = FRAME_BITS * CLKS_PER_BIT;
    localparam int IDW          = $clog2(NUM_REQ);
    localparam int TW           = $clog2(FRAME_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [TW-1:0]      timer, timer_next;
    logic [IDW-1:0]     last_id, last_id_next;
    logic [NUM_REQ-1:0] ack_q, ack_next;
    logic [7:0]         tx_data_q, tx_data_next;
    logic               tx_transmit_q, tx_transmit_next;
    logic               busy_q, busy_next;
    logic [IDW-1:0]     grant_id_q, grant_id_next;

    logic               pick_valid;
    logic [IDW-1:0]     pick_id;
    logic [IDW-1:0]     scan_id;
    logic [7:0]         pick_byte;

    // Scan farthest offset first so the nearest requester after last_id wins.
    always_comb begin : rr_scan
        pick_valid = 1'b0;
        pick_id    = '0;
        scan_id    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            scan_id = IDW'((int'(last_id) + k) % NUM_REQ);
            if (bus.req[scan_id]) begin
                pick_valid = 1'b1;
                pick_id    = scan_id;
            end
        end
    end

    always_comb begin : byte_mux
        pick_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_id == IDW'(i)) begin
                pick_byte = bus.req_data[i*8 +: 8];
            end
        end
    end

    always_comb begin : fsm_next
        state_next       = state;
        timer_next       = timer;
        last_id_next     = last_id;
        ack_next         = '0;
        tx_data_next     = tx_data_q;
        tx_transmit_next = tx_transmit_q;
        busy_next        = busy_q;
        grant_id_next    = grant_id_q;

        case (state)
            IDLE: begin
                if (pick_valid) begin
                    ack_next[pick_id] = 1'b1;
                    tx_data_next      = pick_byte;
                    grant_id_next     = pick_id;
                    last_id_next      = pick_id;
                    tx_transmit_next  = 1'b1;
                    busy_next         = 1'b1;
                    timer_next        = TW'(1);
                    state_next        = SEND;
                end
            end
            SEND: begin
                timer_next = timer + 1'b1;
                if (timer == TW'(HOLD_CYCLES)) begin
                    tx_transmit_next = 1'b0;
                    state_next       = WAIT;
                end
            end
            WAIT: begin
                // Timer saturates at the frame length; it is only cleared by the next grant.
                if (timer == TW'(FRAME_CYCLES)) begin
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin : fsm_reg
        if (reset) begin
            state         <= IDLE;
            timer         <= '0;
            last_id       <= IDW'(NUM_REQ - 1);
            ack_q         <= '0;
            tx_data_q     <= '0;
            tx_transmit_q <= 1'b0;
            busy_q        <= 1'b0;
            grant_id_q    <= '0;
        end else begin
            state         <= state_next;
            timer         <= timer_next;
            last_id       <= last_id_next;
            ack_q         <= ack_next;
            tx_data_q     <= tx_data_next;
            tx_transmit_q <= tx_transmit_next;
            busy_q        <= busy_next;
            grant_id_q    <= grant_id_next;
        end
    end

    assign bus.ack         = ack_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_transmit = tx_transmit_q;
    assign bus.busy        = busy_q;
    assign bus.grant_id    = grant_id_q;
endmodule
